// File: rtl/la_pkg.sv
// Shared constants and state encoding for the logic-analyser trigger block.
package la_pkg;

  // Probed bus width.
  localparam int unsigned LA_DW = 32;

  // Largest supported pre-trigger history depth.
  localparam int unsigned LA_PRE_DEPTH_MAX = 64;

  // State codes are read back by software, so the encoding is fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFill    = 3'd1,
    StArmed   = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4
  } la_state_e;

endpackage

// File: rtl/la_delay_line.sv
// Fixed-depth shift register holding the most recent W-bit samples.
module la_delay_line #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] taps [DEPTH];

  // Shift one stage per cycle; reset clears the whole history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/la_trigger_ctrl.sv
// Trigger/capture controller feeding the analyser FIFO write port.
// Keeps a pre-trigger history and, on trigger, streams the window
// history + trigger word + PostCount samples into the FIFO.
module la_trigger_ctrl
  import la_pkg::*;
#(
  parameter int unsigned PRE_DEPTH = 8,   // 1..LA_PRE_DEPTH_MAX
  parameter int unsigned CNT_W     = 16
) (
  input  logic             DClk,
  input  logic             rst,
  input  logic [LA_DW-1:0] Data,
  input  logic [LA_DW-1:0] TrigValue,
  input  logic [LA_DW-1:0] TrigMask,
  input  logic             TrigEdge,
  input  logic             ForceTrig,
  input  logic [CNT_W-1:0] PostCount,
  input  logic             Arm,
  input  logic             Full,
  output logic [LA_DW-1:0] WrData,
  output logic             WrEn,
  output logic             Triggered,
  output logic             Done,
  output logic             Overflow,
  output logic [2:0]       State
);

  // Seven extra bits cover PRE_DEPTH up to 64 so the window count never wraps.
  localparam int unsigned     RemW      = CNT_W + 7;
  localparam logic [RemW-1:0] PreDepthW = RemW'(PRE_DEPTH);
  localparam logic [6:0]      FillLast  = 7'(PRE_DEPTH - 1);

  logic [LA_DW-1:0] samp_q;
  logic             match_prev_q;
  logic             arm_q;
  logic             arm_rise;
  logic             match;
  logic             fire;
  logic [LA_DW-1:0] hist_tail;

  la_state_e        state_q;
  logic [6:0]       fill_q;
  logic [RemW-1:0]  rem_q;
  logic             wr_valid_q;
  logic [LA_DW-1:0] wr_data_q;
  logic             trig_q;
  logic             done_q;
  logic             ovf_q;

  // Register the probed bus, the previous match result and Arm for edge detection.
  always_ff @(posedge DClk) begin
    if (rst) begin
      samp_q       <= '0;
      match_prev_q <= 1'b0;
      arm_q        <= 1'b0;
    end else begin
      samp_q       <= Data;
      match_prev_q <= match;
      arm_q        <= Arm;
    end
  end

  // One stage deeper than PRE_DEPTH: the extra stage covers the fire-decision
  // cycle, so the tail lines up with the oldest window word when capture starts.
  la_delay_line #(
    .DEPTH (PRE_DEPTH + 1),
    .W     (LA_DW)
  ) u_hist (
    .clk  (DClk),
    .rst  (rst),
    .din  (samp_q),
    .dout (hist_tail)
  );

  // Masked compare on the registered sample; edge mode needs a fresh match.
  always_comb begin
    arm_rise = Arm & ~arm_q;
    match    = ((samp_q ^ TrigValue) & TrigMask) == '0;
    fire     = (match & (~TrigEdge | ~match_prev_q)) | ForceTrig;
  end

  // Acquisition FSM with registered status and FIFO write outputs.
  always_ff @(posedge DClk) begin
    if (rst) begin
      state_q    <= StIdle;
      fill_q     <= '0;
      rem_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      // A word presented while the FIFO is full is lost.
      if (wr_valid_q && Full) begin
        ovf_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          trig_q <= 1'b0;
          done_q <= 1'b0;
          if (arm_rise) begin
            state_q <= StFill;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
          end
        end
        StFill: begin
          if (!Arm) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
          end else begin
            fill_q <= fill_q + 7'd1;
            if (fill_q == FillLast) begin
              state_q <= StArmed;
            end
          end
        end
        StArmed: begin
          if (!Arm) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
          end else if (fire) begin
            state_q <= StCapture;
            trig_q  <= 1'b1;
            rem_q   <= PreDepthW + {7'd0, PostCount};
          end
        end
        StCapture: begin
          if (!Arm) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
          end else begin
            wr_valid_q <= 1'b1;
            wr_data_q  <= hist_tail;
            if (rem_q == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
        end
        StDone: begin
          if (!Arm) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Full gates the write strobe combinationally so the FIFO never sees a write when full.
  always_comb begin
    WrEn      = wr_valid_q & ~Full;
    WrData    = wr_data_q;
    Triggered = trig_q;
    Done      = done_q;
    Overflow  = ovf_q;
    State     = state_q;
  end

endmodule

// File: doc/la_trigger_ctrl.md
# la_trigger_ctrl

Trigger and capture controller for the FIFO logic analyser, in the `DClk` domain directly upstream of the analyser FIFO's write port. It compares the probed 32-bit bus against a masked trigger pattern and holds a fixed-depth pre-trigger history in a delay line. On trigger it drives FIFO write-enable and data for a window of `PRE_DEPTH + 1 + PostCount` samples, so the FIFO holds the history before the event, the trigger word, and the post-trigger samples. Configuration arrives as static levels from the parent's bus registers (trigger, control, post-count).

## Interface
- `PRE_DEPTH`, 8: pre-trigger samples kept (1..64).
- `CNT_W`, 16: width of the post-trigger counter.
- `DClk` in 1: the only clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Data` in 32: probed bus, sampled every `DClk`.
- `TrigValue` in 32: trigger pattern.
- `TrigMask` in 32: 1 = bit compared, 0 = don't care.
- `TrigEdge` in 1: 1 = fire only on a match that follows a non-match.
- `ForceTrig` in 1: software trigger; fires regardless of match.
- `PostCount` in `CNT_W`: number of samples written after the trigger word.
- `Arm` in 1: level input; its rising edge starts an acquisition, and dropping it aborts.
- `Full` in 1: FIFO full flag.
- `WrData` out 32: FIFO write data.
- `WrEn` out 1: FIFO write enable; already gated by `Full`.
- `Triggered` out 1: set on the trigger edge; cleared in IDLE.
- `Done` out 1: high in DONE.
- `Overflow` out 1: sticky, set when a window sample is dropped because of `Full`; cleared on a new arm or reset.
- `State` out 3: state code, for status readback.

## Operation
- Match term: `((S ^ TrigValue) & TrigMask) == 0`, where S is the registered sample. With `TrigEdge=1`, fire requires match(S_k) & !match(S_{k-1}). Fire = that term | `ForceTrig`.
- The delay line shifts every cycle in every state and always holds the last `PRE_DEPTH` samples.
- States and transitions:
  - IDLE (0): go to FILL on `Arm` rising edge. Entering FILL clears `Overflow` and the fill counter.
  - FILL (1): count samples entering the delay line; go to ARMED when count = `PRE_DEPTH`. Triggers are ignored in FILL.
  - ARMED (2): on fire at sample S_k, go to CAPTURE, set `Triggered`, load remaining count = `PRE_DEPTH + PostCount` (total window = `PRE_DEPTH + 1 + PostCount`).
  - CAPTURE (3): each cycle presents one window word and decrements the count; go to DONE after the last word.
  - DONE (4): stay until `Arm` = 0, then go to IDLE.
- In FILL, ARMED or CAPTURE, `Arm` = 0 aborts to IDLE on the next edge. `WrEn` is 0 from that edge on, and words already written stay in the FIFO.
- Full handling: a window word presented while `Full` = 1 is not written (`WrEn` = 0). It sets `Overflow`, but the window still advances, so window length in time is fixed.
- Arithmetic: the counter is `CNT_W + 7` bits wide so `PRE_DEPTH + PostCount` never wraps. `PostCount` = 0 gives a window of `PRE_DEPTH + 1` words.
- `PostCount`, `TrigValue`, `TrigMask` and `TrigEdge` are sampled only on the trigger edge. Changes during CAPTURE have no effect.

## Timing
- Reset values: `WrEn`=0, `WrData`=0, `Triggered`=0, `Done`=0, `Overflow`=0, `State`=IDLE, delay line zeroed. Reset mid-capture returns to IDLE immediately, with no further writes.
- `Data` is registered at edge k (this is S_k). The fire decision is made at edge k+1.
- `WrEn`/`WrData` are registered outputs. The first window word (S_{k-PRE_DEPTH}) is valid from edge k+2. Words follow on consecutive cycles, with S_k at word index `PRE_DEPTH`.
- After an `Arm` rising edge, the earliest accepted trigger is sample `PRE_DEPTH` cycles after FILL is entered.
- `Full` is combinationally gated into `WrEn`. The FIFO's own full latency is the parent's concern.

## Structure
- Package `la_pkg`: state encoding constants (IDLE..DONE), `LA_DW`=32, `PRE_DEPTH` maximum of 64.
- Sub-module `la_delay_line`: parameterised shift register (`DEPTH`, `W`), with synchronous reset that zeroes it.
- The top level holds the FSM, match/edge logic, counters and output registers.

## Test plan
- **Basic capture:** `PRE_DEPTH`=8, `PostCount`=4, mask FFFFFFFF, value 0x55, `Data` = incrementing counter from 0x00, `Arm` raised → 13 words written: 0x4D..0x59, with 0x55 at index 8; `Done`=1; `Overflow`=0.
- **Masked edge trigger:** mask 0x000000FF, value 0x80, `TrigEdge`=1, `Data` held at 0x1280 when armed, then 0x0000, then 0x3480 → fires on 0x3480, not on the held 0x1280.
- **Full back-pressure:** `Full` forced high for 3 cycles mid-window, `PostCount`=10 → 16 words written instead of 19; `Overflow`=1; DONE reached on the same cycle as without `Full`.
- **Abort:** `Arm` dropped 2 cycles into CAPTURE → `WrEn` 0 from the next edge; `State`=IDLE; re-arm clears `Overflow` and `Triggered`.
- **Trigger during FILL:** matching data and `ForceTrig` applied within the first `PRE_DEPTH` cycles after arm → ignored; the first match after FILL fires.
- **Reset mid-capture:** `rst` pulsed during CAPTURE → all outputs return to reset values on that edge; no writes follow.
